phase_select_ctrl: RTL and testbench

- Closed-loop controller generating the 3-bit tap select Q for the 3-to-8 phase/tap decoder in the DLL.
- Filters UP/DN votes from the phase detector, steps Q by ±1 once a vote threshold is reached, and wraps or saturates at the ends.
- Declares lock once the loop dithers around one tap.
- Sits between the phase detector and the decoder; drives the decoder's Q input directly.

---
 rtl/phase_select_ctrl.sv | 139 +++++++++++++
 tb/tb_phase_select_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/phase_select_ctrl.sv
// rtl/phase_select_ctrl.sv - DLL tap-select loop controller with vote filter and lock detect
module phase_select_ctrl #(
  parameter int FILT_LEN = 4,
  parameter int LOCK_CNT = 8,
  parameter bit WRAP     = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       up,
  input  logic       dn,
  output logic [2:0] q,
  output logic       step,
  output logic       step_dir,
  output logic       locked
);

  // Bit 1 of the encoding is the lock flag, so the locked output is a plain flop.
  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_TRACK  = 2'b01,
    S_LOCKED = 2'b10
  } state_t;

  // A vote that lands on +/-FILT_LEN steps instead of being stored.
  localparam logic signed [4:0] C_VMAX = 5'(FILT_LEN - 1);
  localparam logic signed [4:0] C_VMIN = 5'(1 - FILT_LEN);
  localparam logic [7:0]        C_LOCK = 8'(LOCK_CNT);

  state_t             r_state;
  logic [2:0]         r_q;
  logic               r_step;
  logic               r_step_dir;
  logic signed [4:0]  r_vcnt;
  logic [7:0]         r_rcnt;
  logic               r_first;   // no real step yet since leaving IDLE

  state_t             w_state_nx;
  logic [2:0]         w_q_nx;
  logic               w_step_nx;
  logic               w_dir_nx;
  logic signed [4:0]  w_vcnt_nx;
  logic [7:0]         w_rcnt_nx;
  logic [7:0]         w_rinc;
  logic               w_first_nx;
  logic               w_lock_nx;
  logic               w_vote_up;
  logic               w_vote_dn;
  logic               w_hit_up;
  logic               w_hit_dn;
  logic               w_sat;
  logic               w_real;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_q        <= 3'd0;
      r_step     <= 1'b0;
      r_step_dir <= 1'b0;
      r_vcnt     <= 5'sd0;
      r_rcnt     <= 8'd0;
      r_first    <= 1'b1;
    end else begin
      r_state    <= w_state_nx;
      r_q        <= w_q_nx;
      r_step     <= w_step_nx;
      r_step_dir <= w_dir_nx;
      r_vcnt     <= w_vcnt_nx;
      r_rcnt     <= w_rcnt_nx;
      r_first    <= w_first_nx;
    end
  end

  // Next state: vote filter, step/wrap/saturate decision and reversal counting.
  always_comb begin
    w_vote_up  = up & ~dn;
    w_vote_dn  = dn & ~up;
    w_hit_up   = w_vote_up && (r_vcnt == C_VMAX);
    w_hit_dn   = w_vote_dn && (r_vcnt == C_VMIN);
    w_sat      = !WRAP && ((w_hit_up && (r_q == 3'd7)) || (w_hit_dn && (r_q == 3'd0)));
    w_real     = (w_hit_up || w_hit_dn) && !w_sat;
    w_rinc     = (r_rcnt == C_LOCK) ? r_rcnt : r_rcnt + 8'd1;

    w_state_nx = r_state;
    w_q_nx     = r_q;
    w_step_nx  = 1'b0;
    w_dir_nx   = r_step_dir;
    w_vcnt_nx  = r_vcnt;
    w_rcnt_nx  = r_rcnt;
    w_first_nx = r_first;
    w_lock_nx  = (r_state == S_LOCKED);

    if (!en) begin
      // Disabled wins over any pending step; q is frozen.
      w_state_nx = S_IDLE;
      w_vcnt_nx  = 5'sd0;
      w_rcnt_nx  = 8'd0;
      w_first_nx = 1'b1;
    end else begin
      if (w_hit_up || w_hit_dn)
        w_vcnt_nx = 5'sd0;
      else if (w_vote_up)
        w_vcnt_nx = r_vcnt + 5'sd1;
      else if (w_vote_dn)
        w_vcnt_nx = r_vcnt - 5'sd1;

      if (w_sat) begin
        w_rcnt_nx = 8'd0;
      end else if (w_real) begin
        w_q_nx    = w_hit_up ? r_q + 3'd1 : r_q - 3'd1;
        w_step_nx = 1'b1;
        w_dir_nx  = w_hit_up;
        if (r_first) begin
          w_first_nx = 1'b0;
        end else if (w_hit_up != r_step_dir) begin
          w_rcnt_nx = w_rinc;
          if (w_rinc == C_LOCK)
            w_lock_nx = 1'b1;
        end else begin
          // Two steps the same way means the loop is slewing, not dithering.
          w_rcnt_nx = 8'd0;
          w_lock_nx = 1'b0;
        end
      end

      w_state_nx = w_lock_nx ? S_LOCKED : S_TRACK;
    end
  end

  // Outputs straight from registers.
  always_comb begin
    q        = r_q;
    step     = r_step;
    step_dir = r_step_dir;
    locked   = r_state[1];
  end

endmodule

// File: tb/tb_phase_select_ctrl.sv
// tb/tb_phase_select_ctrl.sv - self-checking bench for phase_select_ctrl (wrap and saturate builds)
module tb_phase_select_ctrl;

  localparam int FILT  = 4;
  localparam int LOCKN = 8;

  logic       clk = 1'b0;
  logic       rst_n, en, up, dn;
  logic [2:0] q_w, q_s;
  logic       st_w, st_s, dir_w, dir_s, lk_w, lk_s;

  always #5 clk = ~clk;

  phase_select_ctrl #(.FILT_LEN(FILT), .LOCK_CNT(LOCKN), .WRAP(1'b1)) u_wrap (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .dn(dn),
    .q(q_w), .step(st_w), .step_dir(dir_w), .locked(lk_w)
  );

  phase_select_ctrl #(.FILT_LEN(FILT), .LOCK_CNT(LOCKN), .WRAP(1'b0)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .dn(dn),
    .q(q_s), .step(st_s), .step_dir(dir_s), .locked(lk_s)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model, index 0 = wrapping build, 1 = saturating build.
  int m_q[2], m_v[2], m_r[2];
  bit m_dir[2], m_lock[2], m_first[2], m_step[2];

  typedef struct {
    bit en, up, dn;
    int q;
    bit step;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_q[k] = 0; m_v[k] = 0; m_r[k] = 0;
      m_dir[k] = 0; m_lock[k] = 0; m_first[k] = 1; m_step[k] = 0;
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      bit d;
      m_step[k] = 0;
      if (!en) begin
        m_v[k] = 0; m_r[k] = 0; m_lock[k] = 0; m_first[k] = 1;
      end else begin
        if (up && !dn) m_v[k]++;
        else if (dn && !up) m_v[k]--;
        if (m_v[k] == FILT || m_v[k] == -FILT) begin
          d = (m_v[k] > 0);
          m_v[k] = 0;
          if (k == 1 && ((d && m_q[k] == 7) || (!d && m_q[k] == 0))) begin
            m_r[k] = 0;
          end else begin
            m_q[k] = (m_q[k] + (d ? 1 : 7)) % 8;
            m_step[k] = 1;
            if (m_first[k]) m_first[k] = 0;
            else if (d != m_dir[k]) begin
              if (m_r[k] < LOCKN) m_r[k]++;
              if (m_r[k] == LOCKN) m_lock[k] = 1;
            end else begin
              m_r[k] = 0;
              m_lock[k] = 0;
            end
            m_dir[k] = d;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    check("wrap.q",      int'(q_w),   m_q[0]);
    check("wrap.step",   int'(st_w),  int'(m_step[0]));
    check("wrap.dir",    int'(dir_w), int'(m_dir[0]));
    check("wrap.locked", int'(lk_w),  int'(m_lock[0]));
    check("sat.q",       int'(q_s),   m_q[1]);
    check("sat.step",    int'(st_s),  int'(m_step[1]));
    check("sat.dir",     int'(dir_s), int'(m_dir[1]));
    check("sat.locked",  int'(lk_s),  int'(m_lock[1]));
  endtask

  task automatic cycle(input bit e, input bit u, input bit d);
    en = e; up = u; dn = d;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) cycle(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int target, p;
    bit e, u, d;

    rst_n = 1'b0; en = 1'b0; up = 1'b0; dn = 1'b0;
    model_reset();
    repeat (3) cycle(1'b0, 1'b1, 1'b0);
    check("rst.q",      int'(q_w),  0);
    check("rst.step",   int'(st_w), 0);
    check("rst.locked", int'(lk_w), 0);
    check("rst.dir",    int'(dir_s), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Opposing and null votes: net +4 only on the last entry.
    tbl[0] = '{1'b1, 1'b1, 1'b0, 0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 0, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 0, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 0, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 0, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 0, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      cycle(tbl[i].en, tbl[i].up, tbl[i].dn);
      check("tbl.q",    int'(q_w),  tbl[i].q);
      check("tbl.step", int'(st_w), int'(tbl[i].step));
      check("tbl.sat_q", int'(q_s), tbl[i].q);
    end

    // Fresh start: constant up steps on every 4th edge.
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      if (i == 3) check("en.step3", int'(st_w), 0);
      if (i == 4) begin
        check("en.q4", int'(q_w), 1);
        check("en.step4", int'(st_w), 1);
      end
      if (i == 8) check("en.q8", int'(q_w), 2);
    end

    // Up to tap 7, then across the top end.
    repeat (20) cycle(1'b1, 1'b1, 1'b0);
    check("top.wrap_q", int'(q_w), 7);
    check("top.sat_q",  int'(q_s), 7);
    repeat (4) cycle(1'b1, 1'b1, 1'b0);
    check("wrap.q0",    int'(q_w),  0);
    check("wrap.step",  int'(st_w), 1);
    check("wrap.dir",   int'(dir_w), 1);
    check("sat.hold7",  int'(q_s),  7);
    check("sat.nostep", int'(st_s), 0);
    repeat (4) cycle(1'b1, 1'b0, 1'b1);
    check("wrap.back7", int'(q_w), 7);
    check("sat.q6",     int'(q_s), 6);
    repeat (24) cycle(1'b1, 1'b0, 1'b1);
    check("sat.q0", int'(q_s), 0);
    repeat (4) cycle(1'b1, 1'b0, 1'b1);
    check("sat.hold0",   int'(q_s),  0);
    check("sat.nostep0", int'(st_s), 0);
    check("wrap.q0b",    int'(q_w),  0);

    // Dither 0/1 until lock, then slew up to break it.
    cycle(1'b0, 1'b0, 1'b0);
    for (int s = 1; s <= 9; s++) begin
      repeat (4) cycle(1'b1, s[0], !s[0]);
      if (s == 8) check("lock.before", int'(lk_w), 0);
      if (s == 9) begin
        check("lock.wrap", int'(lk_w), 1);
        check("lock.sat",  int'(lk_s), 1);
        check("lock.q",    int'(q_w),  1);
      end
    end
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      if (i == 3) check("unlock.hold", int'(lk_w), 1);
      if (i == 4) begin
        check("unlock.lk", int'(lk_w), 0);
        check("unlock.q",  int'(q_w),  2);
      end
    end

    // Disable mid-filter discards the partial vote count.
    repeat (3) cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    check("dis.q",    int'(q_w),  3);
    check("dis.lk",   int'(lk_w), 0);
    check("dis.step", int'(st_w), 0);
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      if (i == 3) check("reen.step3", int'(st_w), 0);
      if (i == 4) check("reen.step4", int'(st_w), 1);
    end

    // Reset between edges clears q without a clock.
    #3;
    rst_n = 1'b0;
    #1;
    check("arst.wrap_q", int'(q_w), 0);
    check("arst.sat_q",  int'(q_s), 0);
    model_reset();
    cycle(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Closed-loop style random votes pulling toward a moving target tap.
    for (int b = 0; b < 6; b++) begin
      target = $urandom_range(0, 7);
      for (int i = 0; i < 500; i++) begin
        p = (m_q[0] < target) ? 75 : ((m_q[0] > target) ? 25 : 50);
        e = ($urandom_range(0, 63) != 0);
        u = ($urandom_range(0, 99) < p);
        d = ($urandom_range(0, 99) < (100 - p));
        cycle(e, u, d);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
